mem_bus_arbiter: RTL and testbench

Shares the single external memory bus between the instruction-fetch port (IF) and the MEM-stage data port (DM).
- Sequences one bus transaction at a time with a req/ack handshake.
- Arbitrates round-robin when both ports request together.
- Aborts transactions the slave never acknowledges.
- Drives stall_req to the pipeline control block while any port waits.

---
 rtl/mem_bus_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one external memory bus between
// instruction fetch (IF) and data memory (DM), with ack timeout.
module mem_bus_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   output logic              if_err,

   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [3:0]        dm_sel,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ready,
   output logic              dm_err,

   output logic              bus_req,
   output logic              bus_we,
   output logic [3:0]        bus_sel,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_ack,
   input  logic [DATA_W-1:0] bus_rdata,

   output logic              stall_req
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_IF = 2'd1,
      GNT_DM = 2'd2
   } state_t;

   localparam logic [9:0] TO_LAST = 10'(ACK_TIMEOUT - 1);

   state_t     state;
   logic       last_dm;
   logic [9:0] cnt;

   logic if_elig;
   logic dm_elig;
   logic pick_dm;
   logic timeout;

   // A port still seeing its completion pulse is not eligible again.
   assign if_elig = if_req & ~if_ready;
   assign dm_elig = dm_req & ~dm_ready;
   assign pick_dm = dm_elig & (~if_elig | ~last_dm);
   assign timeout = (cnt == TO_LAST);

   assign stall_req = (if_req & ~if_ready) | (dm_req & ~dm_ready);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         last_dm   <= 1'b0;
         cnt       <= '0;
         if_rdata  <= '0;
         if_ready  <= 1'b0;
         if_err    <= 1'b0;
         dm_rdata  <= '0;
         dm_ready  <= 1'b0;
         dm_err    <= 1'b0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_sel   <= '0;
         bus_addr  <= '0;
         bus_wdata <= '0;
      end else begin
         if_ready <= 1'b0;
         if_err   <= 1'b0;
         dm_ready <= 1'b0;
         dm_err   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (pick_dm) begin
                  state     <= GNT_DM;
                  last_dm   <= 1'b1;
                  cnt       <= '0;
                  bus_req   <= 1'b1;
                  bus_we    <= dm_we;
                  bus_sel   <= dm_sel;
                  bus_addr  <= dm_addr;
                  bus_wdata <= dm_wdata;
               end else if (if_elig) begin
                  state    <= GNT_IF;
                  last_dm  <= 1'b0;
                  cnt      <= '0;
                  bus_req  <= 1'b1;
                  bus_we   <= 1'b0;
                  bus_sel  <= 4'b1111;
                  bus_addr <= if_addr;
               end
            end
            GNT_IF: begin
               if (bus_ack) begin
                  state    <= IDLE;
                  bus_req  <= 1'b0;
                  if_ready <= 1'b1;
                  if_rdata <= bus_rdata;
               end else if (timeout) begin
                  state    <= IDLE;
                  bus_req  <= 1'b0;
                  if_ready <= 1'b1;
                  if_err   <= 1'b1;
               end else begin
                  cnt <= cnt + 10'd1;
               end
            end
            GNT_DM: begin
               if (bus_ack) begin
                  state    <= IDLE;
                  bus_req  <= 1'b0;
                  dm_ready <= 1'b1;
                  if (!bus_we) dm_rdata <= bus_rdata;
               end else if (timeout) begin
                  state    <= IDLE;
                  bus_req  <= 1'b0;
                  dm_ready <= 1'b1;
                  dm_err   <= 1'b1;
               end else begin
                  cnt <= cnt + 10'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a short ack timeout.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        if_err;
   logic        dm_req = 1'b0;
   logic        dm_we = 1'b0;
   logic [3:0]  dm_sel = '0;
   logic [31:0] dm_addr = '0;
   logic [31:0] dm_wdata = '0;
   logic [31:0] dm_rdata;
   logic        dm_ready;
   logic        dm_err;
   logic        bus_req;
   logic        bus_we;
   logic [3:0]  bus_sel;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = '0;
   logic        stall_req;

   int n_tests = 0;
   int n_fail  = 0;

   mem_bus_arbiter #(
      .ADDR_W(32), .DATA_W(32), .ACK_TIMEOUT(4)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_ready(if_ready), .if_err(if_err),
      .dm_req(dm_req), .dm_we(dm_we), .dm_sel(dm_sel),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
      .dm_ready(dm_ready), .dm_err(dm_err),
      .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .stall_req(stall_req)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      if_req = 1'b0;
      dm_req = 1'b0;
      bus_ack = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   // Slave acks after 'waits' non-ack cycles; returns in the ready cycle.
   task automatic slave(input int waits, input logic [31:0] d);
      repeat (waits) tick();
      bus_ack = 1'b1;
      bus_rdata = d;
      tick();
      bus_ack = 1'b0;
      bus_rdata = 32'h0;
   endtask

   int hi;

   initial begin
      // Reset state
      tick();
      tick();
      chk("rst_bus_req", 32'(bus_req), 32'd0);
      chk("rst_bus_addr", bus_addr, 32'd0);
      chk("rst_dm_rdata", dm_rdata, 32'd0);
      chk("rst_if_ready", 32'(if_ready), 32'd0);
      rst = 1'b1;
      tick();

      // 1: reset mid GNT_DM
      dm_req = 1'b1;
      dm_we = 1'b0;
      dm_sel = 4'hF;
      dm_addr = 32'h40;
      tick();
      chk("t1_bus_req", 32'(bus_req), 32'd1);
      chk("t1_bus_addr", bus_addr, 32'h40);
      #2 rst = 1'b0;
      #1;
      chk("t1_async_req", 32'(bus_req), 32'd0);
      chk("t1_async_addr", bus_addr, 32'd0);
      dm_req = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      tick();
      chk("t1_idle_req", 32'(bus_req), 32'd0);
      chk("t1_idle_rdy", 32'(dm_ready), 32'd0);
      chk("t1_idle_stall", 32'(stall_req), 32'd0);

      // 2: single fetch, ack two cycles after bus_req
      if_req = 1'b1;
      if_addr = 32'h10;
      tick();
      chk("t2_req", 32'(bus_req), 32'd1);
      chk("t2_addr", bus_addr, 32'h10);
      chk("t2_we", 32'(bus_we), 32'd0);
      chk("t2_sel", 32'(bus_sel), 32'hF);
      chk("t2_stall", 32'(stall_req), 32'd1);
      tick();
      tick();
      chk("t2_wait_rdy", 32'(if_ready), 32'd0);
      chk("t2_wait_stall", 32'(stall_req), 32'd1);
      slave(0, 32'h3C010001);
      chk("t2_rdy", 32'(if_ready), 32'd1);
      chk("t2_rdata", if_rdata, 32'h3C010001);
      chk("t2_err", 32'(if_err), 32'd0);
      chk("t2_req_low", 32'(bus_req), 32'd0);
      chk("t2_stall_low", 32'(stall_req), 32'd0);
      if_req = 1'b0;
      tick();
      chk("t2_pulse", 32'(if_ready), 32'd0);

      // 3: tie after reset, continuous requests -> DM, IF, DM, IF
      do_reset();
      if_req = 1'b1;
      if_addr = 32'h20;
      dm_req = 1'b1;
      dm_we = 1'b1;
      dm_sel = 4'b0011;
      dm_addr = 32'h100;
      dm_wdata = 32'hDEADBEEF;
      tick();
      chk("t3_g1_we", 32'(bus_we), 32'd1);
      chk("t3_g1_addr", bus_addr, 32'h100);
      chk("t3_g1_wdata", bus_wdata, 32'hDEADBEEF);
      chk("t3_g1_sel", 32'(bus_sel), 32'h3);
      slave(0, 32'h77777777);
      chk("t3_dm_rdy", 32'(dm_ready), 32'd1);
      chk("t3_store_rdata", dm_rdata, 32'd0);
      chk("t3_idle_gap", 32'(bus_req), 32'd0);
      tick();
      chk("t3_g2_req", 32'(bus_req), 32'd1);
      chk("t3_g2_we", 32'(bus_we), 32'd0);
      chk("t3_g2_addr", bus_addr, 32'h20);
      slave(0, 32'h11111111);
      chk("t3_if_rdy", 32'(if_ready), 32'd1);
      chk("t3_if_rdata", if_rdata, 32'h11111111);
      tick();
      chk("t3_g3_addr", bus_addr, 32'h100);
      slave(0, 32'h0);
      chk("t3_g3_rdy", 32'(dm_ready), 32'd1);
      tick();
      chk("t3_g4_addr", bus_addr, 32'h20);
      slave(0, 32'h22222222);
      chk("t3_g4_rdy", 32'(if_ready), 32'd1);
      if_req = 1'b0;
      dm_req = 1'b0;
      tick();
      chk("t3_end_req", 32'(bus_req), 32'd0);

      // Prime dm_rdata with a load
      dm_req = 1'b1;
      dm_we = 1'b0;
      dm_sel = 4'hF;
      dm_addr = 32'h180;
      tick();
      slave(0, 32'h12345678);
      chk("p_rdata", dm_rdata, 32'h12345678);
      dm_req = 1'b0;
      tick();

      // 4: timeout, no ack
      dm_req = 1'b1;
      dm_addr = 32'h200;
      tick();
      hi = 0;
      for (int i = 0; i < 20 && bus_req; i++) begin
         hi++;
         tick();
      end
      chk("t4_high_cycles", 32'(hi), 32'd4);
      chk("t4_rdy", 32'(dm_ready), 32'd1);
      chk("t4_err", 32'(dm_err), 32'd1);
      chk("t4_rdata", dm_rdata, 32'h12345678);
      dm_req = 1'b0;
      tick();
      chk("t4_err_pulse", 32'(dm_err), 32'd0);

      // 5: ack on the timeout cycle wins
      dm_req = 1'b1;
      dm_addr = 32'h204;
      tick();
      slave(3, 32'hCAFEF00D);
      chk("t5_rdy", 32'(dm_ready), 32'd1);
      chk("t5_err", 32'(dm_err), 32'd0);
      chk("t5_rdata", dm_rdata, 32'hCAFEF00D);
      dm_req = 1'b0;
      tick();

      // 6: store then load, spurious ack in IDLE
      dm_req = 1'b1;
      dm_we = 1'b1;
      dm_addr = 32'h300;
      dm_wdata = 32'hA5A5A5A5;
      tick();
      chk("t6_st_we", 32'(bus_we), 32'd1);
      slave(0, 32'h55555555);
      chk("t6_st_rdy", 32'(dm_ready), 32'd1);
      chk("t6_st_rdata", dm_rdata, 32'hCAFEF00D);
      dm_req = 1'b0;
      tick();
      bus_ack = 1'b1;
      bus_rdata = 32'h99999999;
      tick();
      bus_ack = 1'b0;
      chk("t6_spur_dm", 32'(dm_ready), 32'd0);
      chk("t6_spur_if", 32'(if_ready), 32'd0);
      chk("t6_spur_req", 32'(bus_req), 32'd0);
      tick();
      chk("t6_spur_rdata", dm_rdata, 32'hCAFEF00D);
      dm_req = 1'b1;
      dm_we = 1'b0;
      dm_addr = 32'h304;
      tick();
      slave(0, 32'h0BADF00D);
      chk("t6_ld_rdy", 32'(dm_ready), 32'd1);
      chk("t6_ld_rdata", dm_rdata, 32'h0BADF00D);
      dm_req = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
